stopwatch_sequencer: RTL and testbench

//  Central run-control FSM for the stopwatch: start/stop, lap-freeze and clear.

---
 rtl/stopwatch_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_stopwatch_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_sequencer.sv
// stopwatch_sequencer: run-control FSM for the stopwatch. Debounces the three
// buttons, drives the counter chain and display path, and requests display refreshes.
module stopwatch_sequencer #(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int DB_W            = 14
) (
    input  logic       clk,
    input  logic       res,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic       tick_100hz,
    input  logic       disp_ack,
    output logic       counter_ena,
    output logic       counter_clr,
    output logic       display_ena,
    output logic       disp_req,
    output logic [2:0] state
);
    // state   | meaning
    // IDLE    | stopped and cleared, display tracks counters
    // RUN     | counting, display tracks counters
    // LAP     | counting, display frozen on the lap time
    // STOP    | stopped, display tracks counters
    // LAPSTOP | stopped, display still frozen on the lap time
    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_RUN     = 3'b001;
    localparam logic [2:0] ST_LAP     = 3'b010;
    localparam logic [2:0] ST_STOP    = 3'b011;
    localparam logic [2:0] ST_LAPSTOP = 3'b100;

    localparam int B_START = 0;
    localparam int B_LAP   = 1;
    localparam int B_CLEAR = 2;

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]      btn_raw;
    logic [2:0]      sync1_q, sync1_d;
    logic [2:0]      sync2_q, sync2_d;
    logic [2:0]      deb_q, deb_d;
    logic [2:0]      deb_dly_q, deb_dly_d;
    logic [2:0]      press_q, press_d;
    logic [DB_W-1:0] cnt_q [3];
    logic [DB_W-1:0] cnt_d [3];

    logic [2:0] state_q, state_d;
    logic       counter_ena_q, counter_ena_d;
    logic       counter_clr_q, counter_clr_d;
    logic       display_ena_q, display_ena_d;
    logic       disp_req_q, disp_req_d;
    logic       enter_q, enter_d;
    logic       rst_pend_q, rst_pend_d;
    logic       first_q, first_d;
    logic       clr_evt;
    logic       req_src;

    assign btn_raw = {btn_clear, btn_lap, btn_start_stop};

    // Counter only runs while the synchronised level disagrees with the accepted one.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        deb_dly_d = deb_q;
        press_d   = deb_q & ~deb_dly_q;
        deb_d     = deb_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Each branch tests presses in clear > start > lap order, only among valid ones.
    always_comb begin
        state_d = state_q;
        clr_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (press_q[B_CLEAR]) begin
                    clr_evt = 1'b1;
                end else if (press_q[B_START]) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (press_q[B_START]) begin
                    state_d = ST_STOP;
                end else if (press_q[B_LAP]) begin
                    state_d = ST_LAP;
                end
            end
            ST_LAP: begin
                if (press_q[B_START]) begin
                    state_d = ST_LAPSTOP;
                end else if (press_q[B_LAP]) begin
                    state_d = ST_RUN;
                end
            end
            ST_STOP: begin
                if (press_q[B_CLEAR]) begin
                    state_d = ST_IDLE;
                    clr_evt = 1'b1;
                end else if (press_q[B_START]) begin
                    state_d = ST_RUN;
                end
            end
            ST_LAPSTOP: begin
                if (press_q[B_CLEAR]) begin
                    state_d = ST_IDLE;
                    clr_evt = 1'b1;
                end else if (press_q[B_START]) begin
                    state_d = ST_LAP;
                end else if (press_q[B_LAP]) begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                clr_evt = 1'b1;
            end
        endcase

        counter_ena_d = (state_d == ST_RUN) || (state_d == ST_LAP);
        display_ena_d = !((state_d == ST_LAP) || (state_d == ST_LAPSTOP));
        counter_clr_d = clr_evt;
        enter_d       = (clr_evt || (state_d != state_q)) && display_ena_d;
        rst_pend_d    = 1'b0;
        first_d       = rst_pend_q;

        req_src    = first_q || enter_q || (tick_100hz && display_ena_q);
        disp_req_d = disp_req_q ? !disp_ack : req_src;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_q         <= '0;
            deb_dly_q     <= '0;
            press_q       <= '0;
            cnt_q         <= '{default: '0};
            state_q       <= ST_IDLE;
            counter_ena_q <= 1'b0;
            counter_clr_q <= 1'b1;
            display_ena_q <= 1'b1;
            disp_req_q    <= 1'b0;
            enter_q       <= 1'b0;
            rst_pend_q    <= 1'b1;
            first_q       <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            deb_q         <= deb_d;
            deb_dly_q     <= deb_dly_d;
            press_q       <= press_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            counter_ena_q <= counter_ena_d;
            counter_clr_q <= counter_clr_d;
            display_ena_q <= display_ena_d;
            disp_req_q    <= disp_req_d;
            enter_q       <= enter_d;
            rst_pend_q    <= rst_pend_d;
            first_q       <= first_d;
        end
    end

    assign counter_ena = counter_ena_q;
    assign counter_clr = counter_clr_q;
    assign display_ena = display_ena_q;
    assign disp_req    = disp_req_q;
    assign state       = state_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Bench for stopwatch_sequencer: history-array model compared every cycle,
// plus hand-computed literal expectations from directed button sequences.
module tb_stopwatch_sequencer;
    localparam int N    = 4;
    localparam int DBW  = 3;
    localparam int MAXE = 4096;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       bss = 1'b0, blap = 1'b0, bclr = 1'b0;
    logic       tick = 1'b0, ack = 1'b0;
    logic       cena, cclr, dena, dreq;
    logic [2:0] st;

    stopwatch_sequencer #(.DEBOUNCE_CYCLES(N), .DB_W(DBW)) dut (
        .clk(clk), .res(res), .btn_start_stop(bss), .btn_lap(blap), .btn_clear(bclr),
        .tick_100hz(tick), .disp_ack(ack), .counter_ena(cena), .counter_clr(cclr),
        .display_ena(dena), .disp_req(dreq), .state(st)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int e = 0;

    // model history, index = clock edge number; value = state after that edge
    int st_m  [MAXE];
    bit act_m [MAXE];
    bit clr_m [MAXE];
    bit req_m [MAXE];
    bit res_h [MAXE];
    bit tick_h[MAXE];
    bit ack_h [MAXE];
    bit sy1_m [3][MAXE];
    bit s_m   [3][MAXE];
    bit deb_m [3][MAXE];

    // next state per (state, button); button 0=start 1=lap 2=clear; -1 = ignored
    int tab [5][3] = '{'{1, -1, 0}, '{3, 2, -1}, '{4, 1, -1}, '{1, -1, 0}, '{2, 3, 0}};
    int order [3]  = '{2, 0, 1};

    function automatic bit dsp_of(int s);
        return !(s == 2 || s == 4);
    endfunction

    function automatic bit ena_of(int s);
        return (s == 1 || s == 2);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        int  n;
        int  cur, nst;
        bit  act, found, flip, enter, first, src;
        bit  raw [3];
        bit  pr  [3];
        n      = e + 1;
        raw[0] = bss; raw[1] = blap; raw[2] = bclr;
        res_h[n]  = res;
        tick_h[n] = tick;
        ack_h[n]  = ack;
        for (int b = 0; b < 3; b++) begin
            if (res) begin
                sy1_m[b][n] = 1'b0;
                s_m[b][n]   = 1'b0;
                deb_m[b][n] = 1'b0;
            end else begin
                sy1_m[b][n] = raw[b];
                s_m[b][n]   = sy1_m[b][n-1];
                flip = (n > N);
                for (int k = 1; k <= N; k++)
                    if (n > N && s_m[b][n-k] == deb_m[b][n-1]) flip = 1'b0;
                deb_m[b][n] = flip ? !deb_m[b][n-1] : deb_m[b][n-1];
            end
            pr[b] = (n >= 3) && !res_h[n-1] && deb_m[b][n-2] && !deb_m[b][n-3];
        end
        cur = st_m[n-1]; nst = cur; act = 1'b0; found = 1'b0;
        if (cur > 4) begin
            nst = 0; act = 1'b1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!found && pr[order[k]] && tab[cur][order[k]] >= 0) begin
                    nst   = tab[cur][order[k]];
                    act   = (order[k] == 2);
                    found = 1'b1;
                end
            end
        end
        enter = (n >= 2) && !res_h[n-1] && (st_m[n-1] != st_m[n-2] || act_m[n-1]) && dsp_of(st_m[n-1]);
        first = (n >= 2) && res_h[n-2] && !res_h[n-1];
        src   = first || enter || (tick_h[n] && dsp_of(st_m[n-1]));
        if (res) begin
            st_m[n] = 0; act_m[n] = 1'b0; clr_m[n] = 1'b1; req_m[n] = 1'b0;
        end else begin
            st_m[n]  = nst;
            act_m[n] = act;
            clr_m[n] = act;
            req_m[n] = req_m[n-1] ? !ack_h[n] : src;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check($sformatf("cycle%0d", e), {st, cena, cclr, dena, dreq},
              {3'(st_m[e]), ena_of(st_m[e]), clr_m[e], dsp_of(st_m[e]), req_m[e]});
        if (e >= MAXE - 2) begin
            $display("FAIL model_overflow: edge %0d limit %0d", e, MAXE);
            $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
            $fatal(1, "model history exhausted");
        end
        model_step();
        e++;
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(int k);
        repeat (k) cyc();
    endtask

    task automatic press_btn(int b, int hold);
        if (b == 0) bss = 1'b1; else if (b == 1) blap = 1'b1; else bclr = 1'b1;
        cycles(hold);
        bss = 1'b0; blap = 1'b0; bclr = 1'b0;
        cycles(10);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        cyc();
        ack = 1'b0;
    endtask

    initial begin
        st_m[0] = 0; clr_m[0] = 1'b1; res_h[0] = 1'b1;
        @(posedge clk);
        #1;

        // 1: reset and first refresh request
        cycles(2);
        check("clr_in_reset", cclr, 1);
        res = 1'b0;
        cyc();
        check("clr_after_reset", cclr, 0);
        check("state_after_reset", st, 0);
        check("dena_after_reset", dena, 1);
        check("req_cycle1", dreq, 0);
        cyc();
        check("req_cycle2", dreq, 1);
        ack_pulse();
        check("req_acked", dreq, 0);

        // 2: start latency and stop
        bss = 1'b1;
        cycles(7);
        check("start_not_yet", st, 0);
        cyc();
        check("start_state", st, 1);
        check("start_ena", cena, 1);
        cycles(2);
        bss = 1'b0;
        cycles(10);
        bss = 1'b1;
        cycles(8);
        check("stop_state", st, 3);
        check("stop_ena", cena, 0);
        cycles(2);
        bss = 1'b0;
        cycles(10);
        press_btn(0, 10);
        check("rerun_state", st, 1);

        // 3: bounce rejected, then a clean lap
        for (int i = 0; i < 3; i++) begin
            blap = 1'b1; cycles(2);
            blap = 1'b0; cycles(2);
        end
        cycles(6);
        check("bounce_ignored", st, 1);
        blap = 1'b1;
        cycles(6);
        blap = 1'b0;
        cycles(4);
        check("lap_state", st, 2);
        check("lap_dena", dena, 0);
        check("lap_ena", cena, 1);

        // 6: clear ignored in LAP, tick ignored while frozen, LAP->LAPSTOP->STOP
        cycles(8);
        press_btn(2, 6);
        check("clear_in_lap", st, 2);
        ack_pulse();
        check("req_low_in_lap", dreq, 0);
        tick = 1'b1; cyc(); tick = 1'b0; cyc();
        check("tick_frozen", dreq, 0);
        bss = 1'b1;
        cycles(8);
        check("lapstop_state", st, 4);
        check("lapstop_ena", cena, 0);
        check("lapstop_dena", dena, 0);
        cycles(2);
        bss = 1'b0;
        cycles(10);
        check("lapstop_req", dreq, 0);
        blap = 1'b1;
        cycles(8);
        check("unfreeze_state", st, 3);
        check("unfreeze_req_early", dreq, 0);
        cyc();
        check("unfreeze_req", dreq, 1);
        cyc();
        blap = 1'b0;
        cycles(10);

        // 4: start and clear together in STOP -> clear wins
        bss = 1'b1; bclr = 1'b1;
        cycles(7);
        check("clr_not_yet", cclr, 0);
        cyc();
        check("clear_state", st, 0);
        check("clear_pulse", cclr, 1);
        check("clear_ena", cena, 0);
        cyc();
        check("clear_pulse_end", cclr, 0);
        check("clear_stays_idle", st, 0);
        bss = 1'b0; bclr = 1'b0;
        cycles(10);

        // 5: tick coalescing and handshake
        press_btn(0, 6);
        check("run_again", st, 1);
        ack_pulse();
        check("req_clear5", dreq, 0);
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1; cyc(); tick = 1'b0;
            check("tick_req", dreq, 1);
            cycles(4);
            check("coalesced", dreq, 1);
        end
        ack_pulse();
        check("ack_drop", dreq, 0);
        cycles(3);
        check("stays_low", dreq, 0);
        tick = 1'b1; cyc(); tick = 1'b0;
        check("req_retick", dreq, 1);
        ack = 1'b1; tick = 1'b1; cyc(); ack = 1'b0; tick = 1'b0;
        check("ack_with_tick", dreq, 0);
        cyc();
        check("coalesce_on_ack", dreq, 0);
        press_btn(2, 6);
        check("clear_in_run", st, 1);

        // mid-operation reset abandons a pending request
        tick = 1'b1; cyc(); tick = 1'b0;
        check("req_before_res", dreq, 1);
        res = 1'b1;
        cyc();
        check("res_req", dreq, 0);
        check("res_state", st, 0);
        check("res_clr", cclr, 1);
        cyc();
        res = 1'b0;
        cyc();
        check("post_res_req1", dreq, 0);
        cyc();
        check("post_res_req2", dreq, 1);
        cycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
